vga_scanout: RTL and testbench

Parametrised VGA scan-out engine: owns H/V timing, issues framebuffer read coordinates, aligns returned pixel data with delayed sync/blank, and drives the DAC pins. It supersedes the fixed 640x480, 3-bit, divide-by-2 output stage. It adds configurable pixel width, clock ratio, sync polarity and framebuffer read latency, plus built-in test-pattern modes. It sits between the framebuffer/glyph memories and the board VGA connector.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_timing.sv | 66 ++++++
 rtl/vga_scanout.sv | 143 ++++++++++++++
 tb/tb_vga_scanout.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan-out engine: pattern mode codes and 640x480@60 timing defaults.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
// Ports: none.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_FB    = 2'b00,
    MODE_SOLID = 2'b01,
    MODE_BARS  = 2'b10,
    MODE_CHECK = 2'b11
  } mode_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int h_total(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider plus horizontal/vertical counters with active-area and sync decode.
// Latency: decodes are combinational from the counter registers; counters advance on pix_en.
// Backpressure: none, free-running once out of reset.
// Ports: clk/rst (sync, active-low); pix_en tick strobe; h/v counters; active, hsync, vsync
// (hsync/vsync are logical "asserted" flags, polarity is applied by the caller).
module vga_timing import vga_pkg::*; #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_en,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          active,
  output logic          hsync,
  output logic          vsync
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (CLK_DIV == 1) begin : g_nodiv
    assign pix_en = 1'b1;
  end else begin : g_div
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
    logic [PW-1:0] phase;

    always_ff @(posedge clk) begin
      if (!rst)               phase <= '0;
      else if (phase == LAST) phase <= '0;
      else                    phase <= phase + 1'b1;
    end

    assign pix_en = (phase == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h == HW'(H_TOTAL - 1)) begin
        h <= '0;
        v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign active = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
  assign hsync  = (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync  = (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: issues framebuffer reads, delays sync/blank to meet the returned pixel, drives DAC pins.
// Latency: FB_LAT+1 pixel ticks from counter value to pins; fb_pixel sampled FB_LAT ticks after fb_req.
// Backpressure: none; the framebuffer must answer every request on time.
// Ports: clk/rst (sync, active-low); mode/solid_color pattern select; fb_x/fb_y/fb_req read request;
// fb_pixel read data; pixel/hsync_out/vsync_out to the connector; frame_start marks pixel (0,0) out.
module vga_scanout import vga_pkg::*; #(
  parameter int PIXEL_W  = 3,
  parameter int CLK_DIV  = 2,
  parameter int FB_LAT   = 1,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic [PIXEL_W-1:0]          solid_color,
  output logic [$clog2(H_ACTIVE)-1:0] fb_x,
  output logic [$clog2(V_ACTIVE)-1:0] fb_y,
  output logic                        fb_req,
  input  logic [PIXEL_W-1:0]          fb_pixel,
  output logic [PIXEL_W-1:0]          pixel,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        frame_start
);

  localparam int HW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int LT = FB_LAT - 1;

  typedef struct packed {
    logic          act;
    logic          hs;
    logic          vs;
    logic          fs;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
  } stage_t;

  logic          pix_en, active, hsync, vsync;
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  vga_timing #(
    .CLK_DIV(CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h(h), .v(v),
    .active(active), .hsync(hsync), .vsync(vsync)
  );

  stage_t       head;
  stage_t       pipe [FB_LAT];
  mode_e        sh_mode;
  logic [PIXEL_W-1:0] sh_solid;
  logic [PIXEL_W-1:0] color;

  always_comb begin
    head     = '0;
    head.act = active;
    head.hs  = hsync;
    head.vs  = vsync;
    head.fs  = (h == '0) && (v == '0);
    head.h   = h;
    head.v   = v;
  end

  // Request is registered on the same tick the counter value enters the delay line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fb_req <= 1'b0;
      fb_x   <= '0;
      fb_y   <= '0;
    end else begin
      fb_req <= pix_en && active;
      if (pix_en) begin
        fb_x <= h[XW-1:0];
        fb_y <= v[YW-1:0];
      end
    end
  end

  // Delay line length matches the read latency so the tail meets fb_pixel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FB_LAT; i++) pipe[i] <= '0;
    end else if (pix_en) begin
      pipe[0] <= head;
      for (int i = 1; i < FB_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Pattern settings latch as pixel (0,0) enters, so a frame never mixes two modes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_mode  <= MODE_FB;
      sh_solid <= '0;
    end else if (pix_en && head.fs) begin
      sh_mode  <= mode_e'(mode);
      sh_solid <= solid_color;
    end
  end

  always_comb begin
    color = '0;
    if (pipe[LT].act) begin
      case (sh_mode)
        MODE_FB:    color = fb_pixel;
        MODE_SOLID: color = sh_solid;
        MODE_BARS:  color = PIXEL_W'((32'(pipe[LT].h) * 32'd8) / 32'(H_ACTIVE));
        default:    color = (pipe[LT].h[4] ^ pipe[LT].v[4]) ? '1 : '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pixel       <= '0;
      hsync_out   <= ~SYNC_POL;
      vsync_out   <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && pipe[LT].fs;
      if (pix_en) begin
        pixel     <= color;
        hsync_out <= pipe[LT].hs ? SYNC_POL : ~SYNC_POL;
        vsync_out <= pipe[LT].vs ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced 32x24 raster (48x30 total) so whole frames fit in a short run.
// Instance A: CLK_DIV=2, FB_LAT=3, active-low sync, framebuffer/bars. B: CLK_DIV=1, active-high, checker.
// Instance C: CLK_DIV=4, FB_LAT=2, solid colour; used for line period and pattern checks.
module tb_vga_scanout;
  localparam int HA = 32, HF = 4, HS = 8, HB = 4;
  localparam int VA = 24, VF = 2, VS = 2, VB = 2;
  localparam int HT = 48, VT = 30, FR = HT * VT;
  localparam int CD_A = 2, LAT_A = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] mode_a = 2'b00, mode_b = 2'b11, mode_c = 2'b01;
  logic [2:0] sol_c = 3'd5;
  logic [4:0] fbx_a, fby_a, fbx_b, fby_b, fbx_c, fby_c;
  logic       fbreq_a, fbreq_b, fbreq_c;
  logic [2:0] fbpix_a;
  logic [2:0] pix_a, pix_b, pix_c;
  logic       hs_a, vs_a, fs_a, hs_b, vs_b, fs_b, hs_c, vs_c, fs_c;

  vga_scanout #(.PIXEL_W(3), .CLK_DIV(CD_A), .FB_LAT(LAT_A),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .mode(mode_a), .solid_color(3'd0),
    .fb_x(fbx_a), .fb_y(fby_a), .fb_req(fbreq_a), .fb_pixel(fbpix_a),
    .pixel(pix_a), .hsync_out(hs_a), .vsync_out(vs_a), .frame_start(fs_a)
  );

  vga_scanout #(.PIXEL_W(3), .CLK_DIV(1), .FB_LAT(1),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .mode(mode_b), .solid_color(3'd0),
    .fb_x(fbx_b), .fb_y(fby_b), .fb_req(fbreq_b), .fb_pixel(3'd0),
    .pixel(pix_b), .hsync_out(hs_b), .vsync_out(vs_b), .frame_start(fs_b)
  );

  vga_scanout #(.PIXEL_W(3), .CLK_DIV(4), .FB_LAT(2),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
  ) dut_c (
    .clk(clk), .rst(rst), .mode(mode_c), .solid_color(sol_c),
    .fb_x(fbx_c), .fb_y(fby_c), .fb_req(fbreq_c), .fb_pixel(3'd0),
    .pixel(pix_c), .hsync_out(hs_c), .vsync_out(vs_c), .frame_start(fs_c)
  );

  // Framebuffer model for A: returns column mod 8 with a 3-tick read pipeline.
  int         mem_ph;
  logic [2:0] mem0, mem1;
  always @(posedge clk) begin
    if (!rst) mem_ph <= 0;
    else      mem_ph <= (mem_ph == CD_A - 1) ? 0 : mem_ph + 1;
    if (rst && mem_ph == CD_A - 1) begin
      mem0 <= fbx_a[2:0];
      mem1 <= mem0;
    end
  end
  assign fbpix_a = mem1;

  // Sync-assert edge period monitors (clocks between successive assertions).
  int   cyc = 0;
  int   last_a = 0, last_b = 0, last_c = 0, last_va = 0;
  int   per_a = 0, per_b = 0, per_c = 0, per_va = 0;
  logic phs_a = 1'b1, phs_b = 1'b0, phs_c = 1'b1, pvs_a = 1'b1;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (phs_a && !hs_a) begin per_a = cyc - last_a; last_a = cyc; end
    if (!phs_b && hs_b) begin per_b = cyc - last_b; last_b = cyc; end
    if (phs_c && !hs_c) begin per_c = cyc - last_c; last_c = cyc; end
    if (pvs_a && !vs_a) begin per_va = cyc - last_va; last_va = cyc; end
    phs_a = hs_a; phs_b = hs_b; phs_c = hs_c; pvs_a = vs_a;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         fr;
    int         x;
    int         y;
    logic [2:0] pix;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t       vt[$];
  logic [4:0] cap [3*FR];

  task automatic do_reset(input int n);
    int k;
    @(negedge clk);
    rst = 1'b0;
    repeat (n) @(negedge clk);
    chk("rst_a_pixel", pix_a, 0);
    chk("rst_a_syncs", {hs_a, vs_a}, 2'b11);
    chk("rst_a_fb_req", fbreq_a, 0);
    chk("rst_a_frame_start", fs_a, 0);
    chk("rst_b_syncs", {hs_b, vs_b}, 2'b00);
    chk("rst_b_pixel", pix_b, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("a_no_req_first_clock", fbreq_a, 0);
    chk("b_req_first_clock", {fbreq_b, fbx_b, fby_b}, {1'b1, 5'd0, 5'd0});
    @(negedge clk);
    chk("a_first_req_xy", {fbreq_a, fbx_a, fby_a}, {1'b1, 5'd0, 5'd0});
    chk("a_req_one_clock_next", fbreq_a, 1);
    chk("b_frame_start_lat1", fs_b, 1);
    k = 0;
    while (!fs_a && k < 50) begin @(negedge clk); k++; end
    chk("a_req_to_frame_start_clocks", k, LAT_A * CD_A);
  endtask

  initial begin
    int   got, nreq, stab_err, fs_err, err, idx, x, y;
    logic [2:0] ep;
    logic [4:0] ev;

    // Framebuffer frame (mode switched to bars at line 10, so still column mod 8).
    vt.push_back(vec_t'{0,  0,  0, 3'd0, 1'b1, 1'b1});
    vt.push_back(vec_t'{0,  5,  0, 3'd5, 1'b1, 1'b1});
    vt.push_back(vec_t'{0, 13,  3, 3'd5, 1'b1, 1'b1});
    vt.push_back(vec_t'{0, 13, 15, 3'd5, 1'b1, 1'b1});
    vt.push_back(vec_t'{0, 31, 23, 3'd7, 1'b1, 1'b1});
    vt.push_back(vec_t'{0, 32,  5, 3'd0, 1'b1, 1'b1});
    vt.push_back(vec_t'{0, 35,  5, 3'd0, 1'b1, 1'b1});
    vt.push_back(vec_t'{0, 36,  5, 3'd0, 1'b0, 1'b1});
    vt.push_back(vec_t'{0, 43,  5, 3'd0, 1'b0, 1'b1});
    vt.push_back(vec_t'{0, 44,  5, 3'd0, 1'b1, 1'b1});
    vt.push_back(vec_t'{0, 10, 24, 3'd0, 1'b1, 1'b1});
    vt.push_back(vec_t'{0, 10, 26, 3'd0, 1'b1, 1'b0});
    vt.push_back(vec_t'{0, 40, 27, 3'd0, 1'b0, 1'b0});
    vt.push_back(vec_t'{0, 10, 28, 3'd0, 1'b1, 1'b1});
    // Colour bars frame: bar = x*8/32, 4 pixels wide each.
    vt.push_back(vec_t'{1,  0,  0, 3'd0, 1'b1, 1'b1});
    vt.push_back(vec_t'{1,  3,  0, 3'd0, 1'b1, 1'b1});
    vt.push_back(vec_t'{1,  4,  0, 3'd1, 1'b1, 1'b1});
    vt.push_back(vec_t'{1, 15,  7, 3'd3, 1'b1, 1'b1});
    vt.push_back(vec_t'{1, 16,  7, 3'd4, 1'b1, 1'b1});
    vt.push_back(vec_t'{1, 29, 12, 3'd7, 1'b1, 1'b1});
    vt.push_back(vec_t'{1, 31, 23, 3'd7, 1'b1, 1'b1});
    vt.push_back(vec_t'{1, 32,  0, 3'd0, 1'b1, 1'b1});
    vt.push_back(vec_t'{1, 38,  1, 3'd0, 1'b0, 1'b1});
    // Checkerboard on B, sync active-high.
    vt.push_back(vec_t'{2,  0,  0, 3'd0, 1'b0, 1'b0});
    vt.push_back(vec_t'{2, 16,  0, 3'd7, 1'b0, 1'b0});
    vt.push_back(vec_t'{2, 16, 16, 3'd0, 1'b0, 1'b0});
    vt.push_back(vec_t'{2,  0, 16, 3'd7, 1'b0, 1'b0});
    vt.push_back(vec_t'{2, 20,  5, 3'd7, 1'b0, 1'b0});
    vt.push_back(vec_t'{2, 31, 23, 3'd0, 1'b0, 1'b0});
    vt.push_back(vec_t'{2, 40,  0, 3'd0, 1'b1, 1'b0});
    vt.push_back(vec_t'{2, 10, 26, 3'd0, 1'b0, 1'b1});

    do_reset(5);

    // Capture two A frames, one output tick per entry, starting at frame_start.
    got = 0;
    for (int i = 0; i < 4000 && got == 0; i++) begin
      @(negedge clk);
      if (fs_a) got = 1;
    end
    chk("a_frame_start_seen", got, 1);
    nreq = 0; stab_err = 0; fs_err = 0;
    for (int k = 0; k < 2 * FR; k++) begin
      cap[k] = {pix_a, hs_a, vs_a};
      if (fs_a !== ((k % FR) == 0)) fs_err++;
      if (fbreq_a) nreq++;
      if (k == 10 * HT) mode_a = 2'b10;
      for (int s = 1; s < CD_A; s++) begin
        @(negedge clk);
        if ({pix_a, hs_a, vs_a} !== cap[k]) stab_err++;
        if (fs_a) fs_err++;
        if (fbreq_a) nreq++;
      end
      @(negedge clk);
    end
    chk("a_pins_stable_between_ticks", stab_err, 0);
    chk("a_frame_start_pulses", fs_err, 0);
    chk("a_fb_req_count_2_frames", nreq, 2 * HA * VA);

    // Capture one B frame.
    got = 0;
    for (int i = 0; i < 3000 && got == 0; i++) begin
      @(negedge clk);
      if (fs_b) got = 1;
    end
    chk("b_frame_start_seen", got, 1);
    for (int k = 0; k < FR; k++) begin
      cap[2*FR + k] = {pix_b, hs_b, vs_b};
      @(negedge clk);
    end

    // C: solid colour at pixel (0,0).
    got = 0;
    for (int i = 0; i < 7000 && got == 0; i++) begin
      @(negedge clk);
      if (fs_c) got = 1;
    end
    chk("c_frame_start_seen", got, 1);
    chk("c_solid_pixel_00", pix_c, 5);

    chk("a_line_period_clocks", per_a, HT * 2);
    chk("b_line_period_clocks", per_b, HT);
    chk("c_line_period_clocks", per_c, HT * 4);
    chk("a_frame_period_clocks", per_va, FR * 2);

    for (int i = 0; i < vt.size(); i++) begin
      idx = vt[i].fr * FR + vt[i].y * HT + vt[i].x;
      chk($sformatf("vec%0d_f%0d_x%0d_y%0d", i, vt[i].fr, vt[i].x, vt[i].y),
          cap[idx], {vt[i].pix, vt[i].hs, vt[i].vs});
    end

    // Whole-frame sweep of A: column mod 8, then bars, zero in blanking.
    err = 0;
    for (int k = 0; k < 2 * FR; k++) begin
      x  = k % HT;
      y  = (k / HT) % VT;
      ep = 3'd0;
      if (x < HA && y < VA) ep = (k < FR) ? 3'(x % 8) : 3'(x / 4);
      ev = {ep, !(x >= HA + HF && x < HA + HF + HS), !(y >= VA + VF && y < VA + VF + VS)};
      if (cap[k] !== ev) err++;
    end
    chk("a_full_frames_sweep", err, 0);

    // Short reset in the middle of a line restarts at (0,0).
    mode_a = 2'b00;
    repeat (37) @(negedge clk);
    do_reset(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not reach the summary in time");
    $fatal(1);
  end

endmodule
